rv32i_mem_arbiter: RTL

Single-port memory arbiter for the RV32I pipeline. It shares one synchronous single-port word memory of DEPTH_WORDS words between the instruction-fetch (IF) stage and the data (MEM/LSU) stage. Data accesses have fixed priority, and a starvation counter guarantees fetch progress. It grants at most one access per cycle and returns read data with 1-cycle latency. It also flags out-of-range and misaligned accesses without touching memory.

---
 rtl/rv32i_mem_pkg.sv | 12 +
 rtl/rv32i_addr_check.sv | 19 +
 rtl/rv32i_mem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared types and defaults for the RV32I single-port memory arbiter.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_D    = 2'd2
  } resp_owner_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/rv32i_addr_check.sv
// Combinational range/alignment check for one requester port.
module rv32i_addr_check #(
  parameter int ADDR_W = 11
) (
  input  logic [31:0] addr,
  input  logic        chk_be,
  input  logic        we,
  input  logic [3:0]  be,
  output logic        err
);

  logic oor, misalign;

  // Any byte-address bit above the word index means the access is off the end.
  assign oor      = |(addr >> (ADDR_W + 2));
  assign misalign = (|addr[1:0]) | (chk_be & we & ~(|be));
  assign err      = oor | misalign;

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Fetch/data arbiter for one synchronous single-port word memory, data-first with starvation guard.
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS),
  parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  resp_owner_e      resp_owner, resp_owner_nxt;
  logic             resp_err, resp_err_nxt;
  logic             resp_is_write;
  logic             if_bad, d_bad, force_if;

  rv32i_addr_check #(.ADDR_W(ADDR_W)) u_if_chk (
    .addr(if_addr), .chk_be(1'b0), .we(1'b0), .be(4'h0), .err(if_bad)
  );

  rv32i_addr_check #(.ADDR_W(ADDR_W)) u_d_chk (
    .addr(d_addr), .chk_be(1'b1), .we(d_we), .be(d_be), .err(d_bad)
  );

  assign force_if = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
  assign d_gnt    = rst_n && d_req && !force_if;
  assign if_gnt   = rst_n && if_req && (force_if || !d_req);

  always_comb begin
    mem_en         = 1'b0;
    mem_we         = 4'h0;
    mem_addr       = '0;
    mem_wdata      = '0;
    resp_owner_nxt = RESP_NONE;
    resp_err_nxt   = 1'b0;
    if (if_gnt) begin
      resp_owner_nxt = RESP_IF;
      resp_err_nxt   = if_bad;
      if (!if_bad) begin
        mem_en    = 1'b1;
        mem_addr  = if_addr[ADDR_W+1:2];
        mem_wdata = d_wdata;
      end
    end else if (d_gnt) begin
      resp_owner_nxt = RESP_D;
      resp_err_nxt   = d_bad;
      if (!d_bad) begin
        mem_en    = 1'b1;
        mem_addr  = d_addr[ADDR_W+1:2];
        mem_we    = d_we ? d_be : 4'h0;
        mem_wdata = d_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt    <= '0;
      resp_owner    <= RESP_NONE;
      resp_err      <= 1'b0;
      resp_is_write <= 1'b0;
    end else begin
      if (!if_req || if_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      resp_owner    <= resp_owner_nxt;
      resp_err      <= resp_err_nxt;
      resp_is_write <= d_gnt && d_we;
    end
  end

  // Read data only passes for error-free reads on the owning port.
  assign if_rvalid = (resp_owner == RESP_IF);
  assign d_rvalid  = (resp_owner == RESP_D);
  assign if_err    = if_rvalid && resp_err;
  assign d_err     = d_rvalid && resp_err;
  assign if_rdata  = (if_rvalid && !resp_err) ? mem_rdata : 32'h0;
  assign d_rdata   = (d_rvalid && !resp_err && !resp_is_write) ? mem_rdata : 32'h0;

endmodule
